// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding,
// requester count and the rotating priority search used to pick an owner.
package rr_arb_pkg;

  localparam int REQ_COUNT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns {found, idx}: the first requester with req set and not excluded,
  // searching pointer, pointer+1, ... modulo 4.
  function automatic logic [2:0] next_pick(
    input logic [3:0] req,
    input logic [1:0] pointer,
    input logic [3:0] exclude
  );
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      cand = pointer + 2'(i);
      if (!found && req[cand] && !exclude[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux4x1.sv
// Plain 4:1 N-bit multiplexer used as the shared datapath.
module mux4x1 #(
  parameter int N = 4
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  input  logic [1:0]   sel,
  output logic [N-1:0] y
);

  // Select one of the four inputs.
  always_comb begin
    y = {N{1'b0}};
    case (sel)
      2'd0:    y = in0;
      2'd1:    y = in1;
      2'd2:    y = in2;
      2'd3:    y = in3;
      default: y = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters. The owner
// keeps the grant while it requests, but yields after MAX_HOLD consecutive
// cycles whenever someone else is waiting. The last owner always becomes
// lowest priority for the next pick.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [3:0]   req,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         out_valid,
  output logic [N-1:0] out_data
);

  localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_r,   state_s;
  logic [3:0]        gnt_r,     gnt_s;
  logic [1:0]        sel_r,     sel_s;
  logic              valid_r,   valid_s;
  logic [1:0]        pointer_r, pointer_s;
  logic [HOLD_W-1:0] hold_r,    hold_s;

  logic [3:0]        owner_mask_s;
  logic [2:0]        idle_pick_s;
  logic [2:0]        owner_pick_s;
  logic [N-1:0]      mux_y_s;

  assign owner_mask_s = 4'b0001 << sel_r;
  assign idle_pick_s  = next_pick(req, pointer_r, 4'b0000);
  // The pointer already sits at owner+1; the mask additionally keeps the
  // current owner from re-winning when it is the only other candidate.
  assign owner_pick_s = next_pick(req, pointer_r, owner_mask_s);

  // Next-state, grant and hold counter decisions.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    sel_s     = sel_r;
    valid_s   = valid_r;
    pointer_s = pointer_r;
    hold_s    = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (idle_pick_s[2]) begin
          state_s   = ST_GRANT;
          gnt_s     = 4'b0001 << idle_pick_s[1:0];
          sel_s     = idle_pick_s[1:0];
          valid_s   = 1'b1;
          pointer_s = idle_pick_s[1:0] + 2'd1;
          hold_s    = {HOLD_W{1'b0}};
        end else begin
          gnt_s   = 4'b0000;
          valid_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[sel_r]) begin
          if (owner_pick_s[2]) begin
            gnt_s     = 4'b0001 << owner_pick_s[1:0];
            sel_s     = owner_pick_s[1:0];
            valid_s   = 1'b1;
            pointer_s = owner_pick_s[1:0] + 2'd1;
            hold_s    = {HOLD_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
            gnt_s   = 4'b0000;
            valid_s = 1'b0;
            hold_s  = {HOLD_W{1'b0}};
          end
        end else if ((hold_r == HOLD_LAST) && owner_pick_s[2]) begin
          gnt_s     = 4'b0001 << owner_pick_s[1:0];
          sel_s     = owner_pick_s[1:0];
          valid_s   = 1'b1;
          pointer_s = owner_pick_s[1:0] + 2'd1;
          hold_s    = {HOLD_W{1'b0}};
        end else begin
          if (hold_r != HOLD_LAST) begin
            hold_s = hold_r + HOLD_W'(1);
          end else begin
            hold_s = HOLD_LAST;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 4'b0000;
        valid_s = 1'b0;
        hold_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r   <= ST_IDLE;
      gnt_r     <= 4'b0000;
      sel_r     <= 2'd0;
      valid_r   <= 1'b0;
      pointer_r <= 2'd0;
      hold_r    <= {HOLD_W{1'b0}};
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      sel_r     <= sel_s;
      valid_r   <= valid_s;
      pointer_r <= pointer_s;
      hold_r    <= hold_s;
    end
  end

  mux4x1 #(.N(N)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (sel_r),
    .y   (mux_y_s)
  );

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign out_valid = valid_r;
  // Idle forces the shared output to zero rather than showing the last owner.
  assign out_data  = valid_r ? mux_y_s : {N{1'b0}};

endmodule
